// File: rtl/sobel_pkg.sv
// Types and constants shared by the Sobel pipeline stream blocks.
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter width for a dimension of n elements; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gray_pixel_map.sv
// Maps one gray byte to an RGB triple: plain replication, or binarisation
// against THRESH when it is non-zero.
module gray_pixel_map
    import sobel_pkg::*;
#(
    parameter int THRESH = 0
) (
    input  logic [PIX_W-1:0] gray,
    output logic [PIX_W-1:0] red,
    output logic [PIX_W-1:0] green,
    output logic [PIX_W-1:0] blue
);

    logic [PIX_W-1:0] mapped;

    generate
        if (THRESH == 0) begin : g_copy
            assign mapped = gray;
        end else begin : g_thresh
            localparam logic [PIX_W-1:0] THR = PIX_W'(THRESH);
            assign mapped = (gray >= THR) ? '1 : '0;
        end
    endgenerate

    assign red   = mapped;
    assign green = mapped;
    assign blue  = mapped;

endmodule

// File: rtl/gray2rgb_stream.sv
// Frame-armed gray-to-RGB stream stage: one start arms H*W pixels, each is
// mapped to RGB and emitted through a single register slice with sof/eol/eof.
module gray2rgb_stream
    import sobel_pkg::*;
#(
    parameter int H      = 200,
    parameter int W      = 160,
    parameter int THRESH = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             ready,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_red,
    output logic [PIX_W-1:0] m_green,
    output logic [PIX_W-1:0] m_blue,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof
);

    localparam int COL_W = cnt_w(W);
    localparam int ROW_W = cnt_w(H);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             in_hs;
    logic             out_hs;
    logic             last_col;
    logic             last_row;
    logic [PIX_W-1:0] map_red;
    logic [PIX_W-1:0] map_green;
    logic [PIX_W-1:0] map_blue;

    // The slice refills in the same cycle it drains, so full rate needs no bubbles.
    assign s_ready  = (state == RUN) && (!m_valid || m_ready);
    assign in_hs    = s_valid && s_ready;
    assign out_hs   = m_valid && m_ready;
    assign last_col = (col == COL_W'(W - 1));
    assign last_row = (row == ROW_W'(H - 1));
    assign ready    = (state == IDLE);

    gray_pixel_map #(
        .THRESH (THRESH)
    ) u_map (
        .gray  (s_data),
        .red   (map_red),
        .green (map_green),
        .blue  (map_blue)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            done  <= 1'b0;
            col   <= '0;
            row   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        if (last_col) begin
                            col <= '0;
                            row <= last_row ? '0 : row + 1'b1;
                            if (last_row) begin
                                state <= FLUSH;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (!m_valid || out_hs) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flags come from the counters before they advance for this pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_red   <= '0;
            m_green <= '0;
            m_blue  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (in_hs) begin
            m_valid <= 1'b1;
            m_red   <= map_red;
            m_green <= map_green;
            m_blue  <= map_blue;
            m_sof   <= (row == '0) && (col == '0);
            m_eol   <= last_col;
            m_eof   <= last_col && last_row;
        end else if (out_hs) begin
            m_valid <= 1'b0;
        end
    end

endmodule
